// File: rtl/r200dmem_ctrl.sv
// r200 data-memory access controller: turns MEM-stage load/store requests into
// word-aligned valid/ready bus transactions and returns extended load data.
module r200dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              fault_q, fault_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;

    logic              illegal_c, misaligned_c, acc_ok_c, timeout_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, ext_c;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return {24'd0, sh[7:0]};
            3'd5:    return {16'd0, sh[15:0]};
            default: return d;
        endcase
    endfunction

    // Request decode: legality, alignment and store lane placement
    always_comb begin
        illegal_c    = (req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7) ||
                       (req_we && ((req_func3 == 3'd4) || (req_func3 == 3'd5)));
        misaligned_c = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        acc_ok_c     = !illegal_c && !misaligned_c;
        be_c         = 4'b0000;
        wdata_c      = req_wdata;
        case (req_func3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            2'b10:   be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    assign timeout_c = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign ext_c     = load_extend(func3_q, off_q, bus_rdata);
    assign stall     = !rst && req_valid &&
                       (((state_q == S_IDLE) && acc_ok_c) || (state_q == S_REQ) || (state_q == S_RWAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
            func3_q     <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
        end
    end

    // Next state: a completing handshake beats the timeout, which beats entering RWAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: if (req_valid) state_d = acc_ok_c ? S_REQ : S_DONE;
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_ready && (bus_we_q || bus_rvalid)) state_d = S_DONE;
                else if (timeout_c)                        state_d = S_DONE;
                else if (bus_ready)                        state_d = S_RWAIT;
            end
            S_RWAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid || timeout_c) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_valid_d = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        func3_d     = func3_q;
        off_d       = off_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && acc_ok_c) begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = req_we;
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_be_d    = be_c;
                    bus_wdata_d = wdata_c;
                    func3_d     = req_func3;
                    off_d       = req_addr[1:0];
                end else if (req_valid) begin
                    fault_d     = 1'b1;
                    load_data_d = '0;
                end
            end
            S_REQ: begin
                if (bus_ready && (bus_we_q || bus_rvalid)) begin
                    if (!bus_we_q) load_data_d = ext_c;
                end else if (timeout_c) begin
                    fault_d     = 1'b1;
                    load_data_d = '0;
                end else if (!bus_ready) begin
                    bus_valid_d = 1'b1;
                end
            end
            S_RWAIT: begin
                if (bus_rvalid) begin
                    load_data_d = ext_c;
                end else if (timeout_c) begin
                    fault_d     = 1'b1;
                    load_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign load_data = load_data_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_r200dmem_ctrl.sv
// Self-checking bench for r200dmem_ctrl: directed scenarios plus randomized
// accesses, with the bench acting as the memory bus.
module tb_r200dmem_ctrl;
    localparam int unsigned TO = 8;

    logic        clk, rst;
    logic        req_valid, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, fault;
    logic [31:0] load_data;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    r200dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .fault(fault),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and load result
    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic acc_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3 >= 3'd4) return 1'b0;
        return (a % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = acc_size(f3);
        int unsigned mask = (32'd1 << sz) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned sz = acc_size(f3);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned b = (rd >> (8 * (a % 4))) % 256;
        int unsigned h = (rd >> (16 * ((a / 2) % 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // One access from IDLE to DONE; the bench answers bus_valid after rdy_dly
    // cycles and returns read data rv_dly cycles after the ready cycle.
    task automatic run_access(input string nm, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int rdy_dly, input int rv_dly);
        logic ok, tmo, exp_fault, done, seen_bv, hs;
        int wait_n, exp_stall, exp_bv, n_stall, n_bv, vcnt, rcnt;
        logic [31:0] exp_ld;
        ok        = acc_legal(we, f3, a);
        wait_n    = rdy_dly + 1 + (we ? 0 : rv_dly);
        tmo       = ok && (wait_n > int'(TO));
        exp_stall = !ok ? 0 : 1 + (tmo ? int'(TO) : wait_n);
        exp_bv    = !ok ? 0 : ((rdy_dly + 1 < int'(TO)) ? rdy_dly + 1 : int'(TO));
        exp_fault = !ok || tmo;
        exp_ld    = exp_fault ? 32'd0 : exp_load(f3, a, rd);
        done = 1'b0; seen_bv = 1'b0; hs = 1'b0;
        n_stall = 0; n_bv = 0; vcnt = 0; rcnt = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b1; req_we = we; req_func3 = f3;
                req_addr = a; req_wdata = wd; bus_rdata = rd;
            end
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            if (bus_valid) begin
                bus_ready = (vcnt == rdy_dly);
                if (bus_ready) begin
                    hs = 1'b1;
                    bus_rvalid = !we && (rv_dly == 0);
                end
                vcnt++;
            end else if (hs && !we) begin
                rcnt++;
                bus_rvalid = (rcnt == rv_dly);
            end
            #1;
            if (c == 0) check({nm, "_stall_start"}, 32'(stall), 32'(ok));
            if (bus_valid && !seen_bv) begin
                seen_bv = 1'b1;
                check({nm, "_bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
                check({nm, "_bus_we"}, 32'(bus_we), 32'(we));
                check({nm, "_bus_be"}, 32'(bus_be), 32'(exp_be(f3, a)));
                if (we) check({nm, "_bus_wdata"}, bus_wdata, exp_wdata(f3, wd));
            end
            if (bus_valid) n_bv++;
            if (c > 0 && !stall) done = 1'b1;
            else if (stall) n_stall++;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s_done: observed no DONE within 300 cycles expected DONE", nm);
        end
        check({nm, "_fault"}, 32'(fault), 32'(exp_fault));
        if (!we || exp_fault) check({nm, "_load_data"}, load_data, exp_ld);
        check({nm, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        check({nm, "_bus_valid_cycles"}, 32'(n_bv), 32'(exp_bv));
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        check({nm, "_fault_pulse_end"}, 32'(fault), 32'd0);
        check({nm, "_idle_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_bus_valid"}, 32'(bus_valid), 32'd0);
        check({nm, "_bus_we"}, 32'(bus_we), 32'd0);
        check({nm, "_bus_addr"}, bus_addr, 32'd0);
        check({nm, "_bus_be"}, 32'(bus_be), 32'd0);
        check({nm, "_bus_wdata"}, bus_wdata, 32'd0);
        check({nm, "_load_data"}, load_data, 32'd0);
        check({nm, "_fault"}, 32'(fault), 32'd0);
        check({nm, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_func3 = 3'd2; req_addr = 32'h40;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check_all_zero("reset");

        run_access("sw", 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_access("lb", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF01, 0, 0);
        run_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FF01, 0, 0);
        run_access("sh_mis", 1'b1, 3'd1, 32'h201, 32'h1234_5678, 32'h0, 0, 0);
        run_access("lw_mis", 1'b0, 3'd2, 32'h202, 32'h0, 32'h0, 0, 0);
        run_access("lhu_wait", 1'b0, 3'd5, 32'h302, 32'h0, 32'hABCD_1234, 3, 2);
        run_access("lw_tmo", 1'b0, 3'd2, 32'h400, 32'h0, 32'h5555_AAAA, 1000, 0);

        // A response arriving after the timeout must be ignored
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("late_rvalid_load", load_data, 32'd0);
        check("late_rvalid_fault", 32'(fault), 32'd0);
        check("late_rvalid_bus_valid", 32'(bus_valid), 32'd0);

        // Reset while waiting for read data
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h500;
        bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        check("rwait_rst_bus_valid", 32'(bus_valid), 32'd1);
        @(negedge clk);
        bus_ready = 1'b0; rst = 1'b1;
        #1;
        check("rwait_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("post_rst_rvalid_load", load_data, 32'd0);
        check("post_rst_rvalid_fault", 32'(fault), 32'd0);
        run_access("sb_after_rst", 1'b1, 3'd0, 32'h2, 32'h1234_56A5, 32'h0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~32'(acc_size(r_f3) - 1);
            run_access($sformatf("rnd%0d", i), r_we, r_f3, r_addr, $urandom, $urandom,
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
